boot_loader: RTL

- Sits directly upstream of the instruction-source selector.
- Receives a program image as a byte stream from the boot input device and writes it, one 32-bit word at a time, into instruction memory.
- When the image is fully written, raises `source`, which the selector uses to switch fetch from BIOS to instruction memory.
- Also reports malformed images through `error`.

---
 rtl/boot_loader_if.sv | 43 ++++
 rtl/boot_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_if.sv
// ---------------------------------------------------------------------------
// boot_loader_if
//   Groups the boot loader's byte-stream input handshake and its
//   instruction-memory write port.
//
//   byteIn    : incoming image byte
//   byteValid : byteIn holds a valid byte
//   byteReady : loader accepts the byte this cycle
//   memWrite  : instruction-memory write strobe, one cycle per word
//   memAddr   : word address of the current write
//   memData   : word being written
//
//   slave  : the boot loader side
//   master : the byte source / memory side (testbench, system glue)
// ---------------------------------------------------------------------------
interface boot_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            byteIn;
    logic                  byteValid;
    logic                  byteReady;
    logic                  memWrite;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [31:0]           memData;

    modport slave (
        input  byteIn,
        input  byteValid,
        output byteReady,
        output memWrite,
        output memAddr,
        output memData
    );

    modport master (
        output byteIn,
        output byteValid,
        input  byteReady,
        input  memWrite,
        input  memAddr,
        input  memData
    );
endinterface

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
//   Receives a program image as a byte stream (4-byte little-endian word
//   count N followed by N little-endian 32-bit words) and writes the words
//   into instruction memory starting at address 0. When the whole image is
//   written, `source` tells the instruction-source selector to fetch from
//   instruction memory instead of BIOS. Oversized headers raise `error`.
//
//   clock  : system clock, all state updates on posedge
//   rst    : asynchronous active-low reset
//   start  : single-cycle request to begin a load (ignored mid-load)
//   bus    : byte stream handshake + instruction-memory write port
//   busy   : load in progress (header or payload phase)
//   source : image loaded; held until next start or reset
//   error  : image rejected; held until next start or reset
// ---------------------------------------------------------------------------
module boot_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                start,
    boot_loader_if.slave        bus,
    output logic                busy,
    output logic                source,
    output logic                error
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        DONE,
        ERR
    } state_t;

    state_t                state;
    state_t                state_nx;

    logic [1:0]            byte_idx;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [31:0]           len_q;
    logic [31:0]           asm_q;

    logic                  ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_data;

    logic                  hs;
    logic                  word_end;
    logic [4:0]            bit_ofs;
    logic [31:0]           hdr_len;
    logic                  last_word;

    assign hs       = bus.byteValid & ready;
    assign word_end = hs && (byte_idx == 2'd3);
    assign bit_ofs  = {byte_idx, 3'b000};

    // The 4th byte is used straight from the input so the decision and the
    // write happen on the same edge that accepts it.
    assign hdr_len   = {bus.byteIn, len_q[23:0]};
    assign last_word = (32'(word_cnt) == (len_q - 32'd1));

    assign bus.byteReady = ready;
    assign bus.memWrite  = mem_we;
    assign bus.memAddr   = mem_addr;
    assign bus.memData   = mem_data;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = HDR;
            end
            HDR: begin
                if (word_end) begin
                    if (hdr_len == 32'd0)
                        state_nx = DONE;
                    else if (hdr_len > 32'(MAX_WORDS))
                        state_nx = ERR;
                    else
                        state_nx = LOAD;
                end
            end
            LOAD: begin
                // Leaving LOAD on the accepting edge of the final byte makes
                // the last write cycle coincide with DONE, so no stray byte
                // can be handshaked after the image ends.
                if (word_end && last_word) state_nx = DONE;
            end
            DONE, ERR: begin
                if (start) state_nx = HDR;
            end
            default: state_nx = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        ready  = 1'b0;
        busy   = 1'b0;
        source = 1'b0;
        error  = 1'b0;
        unique case (state)
            HDR, LOAD: begin
                ready = 1'b1;
                busy  = 1'b1;
            end
            // source waits until the final word's write strobe has retired.
            DONE:    source = ~mem_we;
            ERR:     error  = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: byte index, header length, word assembly, memory write port
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            byte_idx <= '0;
            word_cnt <= '0;
            len_q    <= '0;
            asm_q    <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        byte_idx <= '0;
                        word_cnt <= '0;
                        len_q    <= '0;
                        asm_q    <= '0;
                    end
                end
                HDR: begin
                    if (hs) begin
                        len_q[bit_ofs +: 8] <= bus.byteIn;
                        byte_idx            <= byte_idx + 2'd1;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        asm_q[bit_ofs +: 8] <= bus.byteIn;
                        byte_idx            <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we   <= 1'b1;
                            mem_addr <= word_cnt[ADDR_WIDTH-1:0];
                            mem_data <= {bus.byteIn, asm_q[23:0]};
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
